demux1_16: RTL and testbench
============================

# demux1_16

Sixteen-lane write-back distributor: accepts one 16-bit ALU result per cycle and the 4-bit destination select, and parks it in the selected lane's holding register until that lane's consumer acknowledges it. It is the fan-out counterpart of the 16:1 ALU operand mux and sits between the ALU result and the sixteen downstream sinks. Per-lane valid/ack handshake provides back-pressure, and a registered occupancy count is exposed for stall logic.

## Interface
- No parameters; data width fixed at 16, lane count fixed at 16.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en  input  1  accept enable; when 0, no new data is accepted, but acks are still honoured.
- in_data  input  16  result word to deliver.
- in_sel  input  4  destination lane index 0..15.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  combinational; lane in_sel can take data this cycle.
- in_bcast  input  1  broadcast request; present only with DEMUX1_16_BCAST_EN.
- out_data  output  256  lane i data is out_data[16*i+15:16*i]; registered.
- out_valid  output  16  bit i set means lane i holds undelivered data; registered.
- out_ack  input  16  bit i: consumer of lane i takes its data this cycle.
- occ_cnt  output  5  registered count of set bits in out_valid, 0..16.

## Operation
- in_ready = en & (~out_valid[in_sel] | out_ack[in_sel]).
- Accept when in_valid & in_ready: lane in_sel data <= in_data and valid <= 1.
- Ack on lane i with out_valid[i]=1 and no same-cycle accept to lane i: valid[i] <= 0. out_data[i] is held; it is not cleared.
- Ack and accept to the same lane in the same cycle: the new word loads and valid stays 1. This is the back-to-back case with no bubble.
- Ack on a lane with valid=0 is ignored.
- Acks on multiple lanes in one cycle are all honoured; at most one lane is loaded per cycle.
- in_valid=1 with in_ready=0: nothing changes. The source must hold in_data/in_sel stable until accepted.
- occ_cnt next = occ_cnt + (accept adds a new valid) − (number of lanes cleared), so it always equals popcount(out_valid).
- en=0: in_ready=0 regardless of lane state; draining by ack continues.

## Timing
- Reset (rst_n low, asynchronous): out_valid=16'h0000, out_data=all 0, occ_cnt=0. Effect is immediate and independent of clk.
- Reset mid-transfer discards all held data. in_ready is 0 only while lane in_sel is full or en=0; after reset all lanes are empty, so in_ready = en.
- Latency: data accepted at edge N is visible on out_data/out_valid after edge N. A consumer can ack it in cycle N+1.
- Throughput: 1 word per cycle when the target lanes are free or acked in the same cycle.
- in_ready has a combinational path from in_sel, en and out_ack. There is no path from in_valid to in_ready.

## Configuration
- DEMUX1_16_BCAST_EN defined: the in_bcast port exists.
  - With in_valid & in_bcast, in_ready = en & (every lane is empty or acked this cycle).
  - On accept, all 16 lanes load in_data, valid=16'hFFFF and occ_cnt=16.
  - in_sel is ignored during a broadcast.
- DEMUX1_16_BCAST_EN undefined: no in_bcast port and no broadcast logic. Behaviour is exactly as in Operation.

## Test plan
- Reset then idle: out_valid=0, occ_cnt=0, in_ready=1 with en=1. Assert rst_n=0 mid-cycle with lanes full: all outputs go to 0 without a clock edge.
- Write 16'hA5A5 to sel=3: next cycle out_valid=16'h0008, out_data[63:48]=16'hA5A5, occ_cnt=1. Ack bit 3: valid clears next cycle and occ_cnt=0.
- Back-pressure: lane 7 full, in_sel=7, in_valid=1, no ack: in_ready=0 and the lane keeps its old data. Same cycle with out_ack[7]=1: in_ready=1, new data loads, valid stays 1, occ_cnt unchanged.
- Fill lanes 0..15 with values 16'h1000+i over 16 cycles: occ_cnt=16. Ack 16'hFFFF in one cycle: out_valid=0 and occ_cnt=0 next cycle.
- en=0 with lanes 2 and 5 full, in_valid=1 to free lane 9: in_ready=0 and lane 9 is not loaded. Ack 16'h0024: both lanes clear and occ_cnt=0.
- With DEMUX1_16_BCAST_EN: broadcast 16'h0F0F while lane 4 is full: in_ready=0. Ack bit 4 in the same cycle: accepted, all lanes =16'h0F0F, occ_cnt=16.

Source files
------------

// File: rtl/demux1_16.sv
// ---------------------------------------------------------------------------
// demux1_16 -- sixteen-lane write-back distributor.
//
// Takes one 16-bit ALU result per cycle together with a 4-bit destination
// lane and parks it in that lane's holding register. The word stays there
// until the lane's consumer acknowledges it. A registered occupancy count
// is provided for upstream stall logic.
//
// Optional feature macro: DEMUX1_16_BCAST_EN
//   When defined, adds the in_bcast input. A broadcast loads in_data into
//   all sixteen lanes at once.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   en         in   1    accept enable (acks are still honoured when low)
//   in_data    in   16   result word to deliver
//   in_sel     in   4    destination lane 0..15
//   in_valid   in   1    in_data/in_sel valid this cycle
//   in_ready   out  1    combinational: the target lane(s) can take data now
//   in_bcast   in   1    broadcast request (only with DEMUX1_16_BCAST_EN)
//   out_data   out  256  lane i word at out_data[16*i +: 16], registered
//   out_valid  out  16   lane i holds undelivered data, registered
//   out_ack    in   16   consumer of lane i takes its word this cycle
//   occ_cnt    out  5    registered popcount of out_valid, 0..16
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream, the source holds in_data/in_sel/in_bcast stable while
// in_valid=1 and in_ready=0. in_ready never depends on in_valid. Downstream,
// lane i is consumed on a rising edge where out_valid[i] and out_ack[i] are
// both high; an ack on an empty lane has no effect.
// ---------------------------------------------------------------------------
module demux1_16 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [15:0]  in_data,
  input  logic [3:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
`ifdef DEMUX1_16_BCAST_EN
  input  logic         in_bcast,
`endif
  output logic [255:0] out_data,
  output logic [15:0]  out_valid,
  input  logic [15:0]  out_ack,
  output logic [4:0]   occ_cnt
);

  logic        is_bcast;
  logic [15:0] lane_free;   // lane is empty, or it is being drained this cycle
  logic        accept;
  logic [15:0] load_mask;   // lanes written on this edge
  logic [15:0] next_valid;
  logic [4:0]  next_cnt;

  always_comb begin
`ifdef DEMUX1_16_BCAST_EN
    is_bcast = in_bcast;
`else
    is_bcast = 1'b0;
`endif

    lane_free = ~out_valid | out_ack;

    // A broadcast must wait until every lane can take the word.
    if (is_bcast) begin
      in_ready = en & (&lane_free);
    end else begin
      in_ready = en & lane_free[in_sel];
    end

    accept = in_valid & in_ready;

    if (!accept) begin
      load_mask = 16'h0000;
    end else if (is_bcast) begin
      load_mask = 16'hFFFF;
    end else begin
      load_mask = 16'h0001 << in_sel;
    end

    // A load overrides a same-cycle ack, so back-to-back words leave no bubble.
    next_valid = load_mask | (out_valid & ~out_ack);

    // occ_cnt is registered alongside out_valid so the two always agree.
    next_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      next_cnt = next_cnt + {4'd0, next_valid[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= '0;
      occ_cnt   <= '0;
    end else begin
      // Acked lanes keep their last word on out_data; only valid drops.
      for (int i = 0; i < 16; i++) begin
        if (load_mask[i]) begin
          out_data[16*i +: 16] <= in_data;
        end
      end
      out_valid <= next_valid;
      occ_cnt   <= next_cnt;
    end
  end

endmodule

// File: tb/tb_demux1_16.sv
// ---------------------------------------------------------------------------
// tb_demux1_16 -- self-checking bench for demux1_16.
//
// A lane-level model (arrays of words and valid flags) tracks what each lane
// must hold. A negedge process compares every DUT output against it each
// cycle and checks each delivered word through an expected queue. Directed
// sequences add literal, hand-computed checks. The broadcast sequence is
// compiled in only when DEMUX1_16_BCAST_EN is defined.
// ---------------------------------------------------------------------------
module tb_demux1_16;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [15:0]  in_data;
  logic [3:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic         in_bcast;
  logic [255:0] out_data;
  logic [15:0]  out_valid;
  logic [15:0]  out_ack;
  logic [4:0]   occ_cnt;

  int errors = 0;
  int checks = 0;

`ifdef DEMUX1_16_BCAST_EN
  localparam bit BCAST_BUILD = 1'b1;
`else
  localparam bit BCAST_BUILD = 1'b0;
`endif

  demux1_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef DEMUX1_16_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .occ_cnt   (occ_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  logic [15:0] m_data  [16];
  bit          m_valid [16];

  function automatic bit bcast_req();
    return BCAST_BUILD && in_bcast;
  endfunction

  function automatic bit model_ready();
    if (!en) return 1'b0;
    if (bcast_req()) begin
      for (int i = 0; i < 16; i++)
        if (m_valid[i] && !out_ack[i]) return 1'b0;
      return 1'b1;
    end
    return !m_valid[in_sel] || out_ack[in_sel];
  endfunction

  function automatic logic [4:0] model_count();
    int n = 0;
    for (int i = 0; i < 16; i++) if (m_valid[i]) n++;
    return 5'(n);
  endfunction

  function automatic logic [15:0] model_valid_vec();
    logic [15:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_valid[i];
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_data[i]  = 16'h0000;
      end
    end else begin
      bit acc;
      acc = in_valid && model_ready();
      for (int i = 0; i < 16; i++) if (out_ack[i]) m_valid[i] = 1'b0;
      if (acc) begin
        if (bcast_req()) begin
          for (int i = 0; i < 16; i++) begin
            m_data[i]  = in_data;
            m_valid[i] = 1'b1;
          end
        end else begin
          m_data[in_sel]  = in_data;
          m_valid[in_sel] = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [255:0] m_flat;
    for (int i = 0; i < 16; i++) m_flat[16*i +: 16] = m_data[i];
    check("model_out_valid", 256'(out_valid), 256'(model_valid_vec()));
    check("model_out_data", out_data, m_flat);
    check("model_occ_cnt", 256'(occ_cnt), 256'(model_count()));
    check("model_in_ready", 256'(in_ready), 256'(model_ready()));
    if (rst_n) begin
      for (int i = 0; i < 16; i++)
        if (m_valid[i] && out_ack[i]) exp_q.push_back(m_data[i]);
      for (int i = 0; i < 16; i++) begin
        if (out_valid[i] && out_ack[i]) begin
          if (exp_q.size() == 0) begin
            check("deliver_unexpected", 256'(i), 256'(16));
          end else begin
            check("deliver_word", 256'(out_data[16*i +: 16]), 256'(exp_q.pop_front()));
          end
        end
      end
      check("deliver_queue_drained", 256'(exp_q.size()), 256'(0));
      exp_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit e, input bit v, input logic [3:0] s,
                       input logic [15:0] d, input logic [15:0] a);
    en = e; in_valid = v; in_sel = s; in_data = d; out_ack = a; in_bcast = 1'b0;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000);
  endtask

  task automatic write_lane(input logic [3:0] s, input logic [15:0] d);
    drive(1'b1, 1'b1, s, d, 16'h0000);
    cyc();
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 16'h0000);
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;

    // Reset then idle.
    check("reset_out_valid", 256'(out_valid), 256'(16'h0000));
    check("reset_occ_cnt", 256'(occ_cnt), 256'(5'd0));
    check("reset_in_ready", 256'(in_ready), 256'(1'b1));
    check("reset_out_data", out_data, 256'(0));

    // Single write to lane 3, then ack.
    write_lane(4'd3, 16'hA5A5);
    check("w3_out_valid", 256'(out_valid), 256'(16'h0008));
    check("w3_data", 256'(out_data[63:48]), 256'(16'hA5A5));
    check("w3_occ", 256'(occ_cnt), 256'(5'd1));
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 16'h0008);
    cyc();
    idle();
    check("ack3_out_valid", 256'(out_valid), 256'(16'h0000));
    check("ack3_occ", 256'(occ_cnt), 256'(5'd0));
    check("ack3_data_held", 256'(out_data[63:48]), 256'(16'hA5A5));

    // Back-pressure on lane 7, then same-cycle ack + accept.
    write_lane(4'd7, 16'h1111);
    drive(1'b1, 1'b1, 4'd7, 16'h2222, 16'h0000);
    #1;
    check("bp7_in_ready", 256'(in_ready), 256'(1'b0));
    cyc();
    check("bp7_data_kept", 256'(out_data[127:112]), 256'(16'h1111));
    out_ack = 16'h0080;
    #1;
    check("b2b7_in_ready", 256'(in_ready), 256'(1'b1));
    cyc();
    idle();
    check("b2b7_data", 256'(out_data[127:112]), 256'(16'h2222));
    check("b2b7_valid", 256'(out_valid), 256'(16'h0080));
    check("b2b7_occ", 256'(occ_cnt), 256'(5'd1));
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 16'h0080);
    cyc();
    idle();

    // Fill all lanes back to back, then drain in one cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'(i), 16'h1000 + 16'(i), 16'h0000);
      cyc();
    end
    idle();
    check("fill_occ", 256'(occ_cnt), 256'(5'd16));
    check("fill_valid", 256'(out_valid), 256'(16'hFFFF));
    check("fill_lane0", 256'(out_data[15:0]), 256'(16'h1000));
    check("fill_lane15", 256'(out_data[255:240]), 256'(16'h100F));
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 16'hFFFF);
    cyc();
    idle();
    check("drain_valid", 256'(out_valid), 256'(16'h0000));
    check("drain_occ", 256'(occ_cnt), 256'(5'd0));

    // Enable low blocks new data; acks still drain.
    write_lane(4'd2, 16'h2020);
    write_lane(4'd5, 16'h5050);
    drive(1'b0, 1'b1, 4'd9, 16'h9999, 16'h0000);
    #1;
    check("en0_in_ready", 256'(in_ready), 256'(1'b0));
    cyc();
    check("en0_valid", 256'(out_valid), 256'(16'h0024));
    check("en0_lane9", 256'(out_data[159:144]), 256'(16'h100F - 16'h0006));
    drive(1'b0, 1'b0, 4'd9, 16'h9999, 16'h0024);
    cyc();
    idle();
    check("en0_drain_valid", 256'(out_valid), 256'(16'h0000));
    check("en0_drain_occ", 256'(occ_cnt), 256'(5'd0));

    // Ack on an empty lane is ignored.
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 16'h0100);
    cyc();
    idle();
    check("ack_empty_occ", 256'(occ_cnt), 256'(5'd0));

`ifdef DEMUX1_16_BCAST_EN
    // Broadcast blocked by a full lane until that lane is acked.
    write_lane(4'd4, 16'h4444);
    drive(1'b1, 1'b1, 4'd0, 16'h0F0F, 16'h0000);
    in_bcast = 1'b1;
    #1;
    check("bc_blocked_ready", 256'(in_ready), 256'(1'b0));
    cyc();
    check("bc_blocked_valid", 256'(out_valid), 256'(16'h0010));
    out_ack = 16'h0010;
    #1;
    check("bc_ready", 256'(in_ready), 256'(1'b1));
    cyc();
    idle();
    check("bc_valid", 256'(out_valid), 256'(16'hFFFF));
    check("bc_occ", 256'(occ_cnt), 256'(5'd16));
    check("bc_lane9", 256'(out_data[159:144]), 256'(16'h0F0F));
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 16'hFFFF);
    cyc();
    idle();
`endif

    // Asynchronous reset mid-cycle with lanes full.
    write_lane(4'd1, 16'hBEEF);
    write_lane(4'd14, 16'hCAFE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 256'(out_valid), 256'(16'h0000));
    check("async_rst_occ", 256'(occ_cnt), 256'(5'd0));
    check("async_rst_data", out_data, 256'(0));
    check("async_rst_ready", 256'(in_ready), 256'(1'b1));
    cyc();
    rst_n = 1'b1;
    write_lane(4'd0, 16'h0001);
    check("post_rst_valid", 256'(out_valid), 256'(16'h0001));
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
